// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational
// instruction memory and queues {pc, instruction} pairs in a 2-entry buffer
// toward decode. Handles redirect/flush, halt-word drain and illegal-address faults.
`timescale 1ns/1ps
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_07FC,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC,
    output logic [31:0] OutPCPlus4,
    output logic        Halted,
    output logic        Fault
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        fault_q, fault_d;
    // Entry 0 is always the head; a pop shifts entry 1 down.
    logic [31:0] e0_pc_q, e0_pc_d, e0_ins_q, e0_ins_d;
    logic [31:0] e1_pc_q, e1_pc_d, e1_ins_q, e1_ins_d;

    logic        pop;
    logic        push;
    logic        room;
    logic [1:0]  count_after_pop;

    // Next-state: redirect beats everything, then limit check, then halt word, then push.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        fault_d  = fault_q;
        e0_pc_d  = e0_pc_q;
        e0_ins_d = e0_ins_q;
        e1_pc_d  = e1_pc_q;
        e1_ins_d = e1_ins_q;
        push     = 1'b0;

        pop             = (count_q != 2'd0) && OutReady;
        count_after_pop = pop ? (count_q - 2'd1) : count_q;
        room            = (count_after_pop != 2'd2);

        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StFetch;
                end
            end
            StFetch, StDrain: begin
                if (RedirectValid) begin
                    // Flush; a same-cycle pop is discarded along with the buffer.
                    count_d = 2'd0;
                    pc_d    = RedirectTarget;
                    if (RedirectTarget[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        state_d = StFetch;
                    end
                end else begin
                    count_d = count_after_pop;
                    if (pop) begin
                        e0_pc_d  = e1_pc_q;
                        e0_ins_d = e1_ins_q;
                    end
                    if (state_q == StFetch) begin
                        if (room) begin
                            if (pc_q > ADDR_LIMIT) begin
                                fault_d = 1'b1;
                                count_d = 2'd0;
                                state_d = StHalt;
                            end else if (ImemInstruction == HALT_WORD) begin
                                state_d = StDrain;
                            end else begin
                                push = 1'b1;
                            end
                        end
                    end else if (count_q == 2'd0) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (push) begin
            pc_d = pc_q + 32'd4;
            if (count_after_pop == 2'd0) begin
                e0_pc_d  = pc_q;
                e0_ins_d = ImemInstruction;
            end else begin
                e1_pc_d  = pc_q;
                e1_ins_d = ImemInstruction;
            end
            count_d = count_after_pop + 2'd1;
        end
    end

    // State, PC and buffer registers with asynchronous reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            fault_q  <= 1'b0;
            e0_pc_q  <= 32'd0;
            e0_ins_q <= 32'd0;
            e1_pc_q  <= 32'd0;
            e1_ins_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
            e0_pc_q  <= e0_pc_d;
            e0_ins_q <= e0_ins_d;
            e1_pc_q  <= e1_pc_d;
            e1_ins_q <= e1_ins_d;
        end
    end

    assign ImemAddress    = pc_q;
    assign OutValid       = (count_q != 2'd0);
    assign OutInstruction = e0_ins_q;
    assign OutPC          = e0_pc_q;
    // Zero while empty so the reset value is 0 rather than RESET_PC+4.
    assign OutPCPlus4     = OutValid ? (e0_pc_q + 32'd4) : 32'd0;
    assign Halted         = (state_q == StHalt);
    assign Fault          = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: vector table, directed corner
// sequences, and randomized episodes against a queue-based reference model.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [31:0] LIMIT = 32'h0000_07FC;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutInstruction;
    logic [31:0] OutPC;
    logic [31:0] OutPCPlus4;
    logic        Halted;
    logic        Fault;

    logic [31:0] l_addr, l_ins, l_out_ins, l_out_pc, l_out_pc4;
    logic        l_valid, l_halted, l_fault;

    logic [31:0] mem [512];

    int total = 0;
    int bad   = 0;

    assign ImemInstruction = mem[int'((ImemAddress >> 2) & 32'h1FF)];
    assign l_ins           = mem[int'((l_addr >> 2) & 32'h1FF)];

    imem_fetch_ctrl dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Start          (Start),
        .ImemAddress    (ImemAddress),
        .ImemInstruction(ImemInstruction),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .OutValid       (OutValid),
        .OutReady       (OutReady),
        .OutInstruction (OutInstruction),
        .OutPC          (OutPC),
        .OutPCPlus4     (OutPCPlus4),
        .Halted         (Halted),
        .Fault          (Fault)
    );

    imem_fetch_ctrl #(.ADDR_LIMIT(32'h0000_000C)) dut_lim (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Start          (Start),
        .ImemAddress    (l_addr),
        .ImemInstruction(l_ins),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .OutValid       (l_valid),
        .OutReady       (OutReady),
        .OutInstruction (l_out_ins),
        .OutPC          (l_out_pc),
        .OutPCPlus4     (l_out_pc4),
        .Halted         (l_halted),
        .Fault          (l_fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    localparam int MIdle = 0, MFetch = 1, MDrain = 2, MHalt = 3;

    ent_t        mq[$];
    logic [31:0] m_pc;
    int          m_mode;
    bit          m_fault;

    function automatic void model_reset();
        mq.delete();
        m_pc    = 32'd0;
        m_mode  = MIdle;
        m_fault = 1'b0;
    endfunction

    function automatic void model_step(bit s, bit r, bit v, logic [31:0] t);
        bit          pop;
        logic [31:0] w;
        ent_t        e;
        pop = (mq.size() != 0) && r;
        if (m_mode == MIdle) begin
            if (s) m_mode = MFetch;
        end else if (m_mode == MFetch || m_mode == MDrain) begin
            if (v) begin
                mq.delete();
                m_pc = t;
                if (t % 4 != 0) begin
                    m_fault = 1'b1;
                    m_mode  = MHalt;
                end else begin
                    m_mode = MFetch;
                end
            end else if (m_mode == MFetch) begin
                if (pop) void'(mq.pop_front());
                if (mq.size() < 2) begin
                    w = mem[int'((m_pc / 4) % 512)];
                    if (m_pc > LIMIT) begin
                        m_fault = 1'b1;
                        mq.delete();
                        m_mode = MHalt;
                    end else if (w == HALT) begin
                        m_mode = MDrain;
                    end else begin
                        e.pc  = m_pc;
                        e.ins = w;
                        mq.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end else begin
                if (mq.size() == 0) m_mode = MHalt;
                else if (pop) void'(mq.pop_front());
            end
        end
    endfunction

    task automatic compare_model(input int cyc);
        chk($sformatf("rnd_valid c%0d", cyc), {31'd0, OutValid}, {31'd0, mq.size() != 0});
        chk($sformatf("rnd_addr c%0d", cyc), ImemAddress, m_pc);
        chk($sformatf("rnd_halted c%0d", cyc), {31'd0, Halted}, {31'd0, m_mode == MHalt});
        chk($sformatf("rnd_fault c%0d", cyc), {31'd0, Fault}, {31'd0, m_fault});
        if (mq.size() != 0) begin
            chk($sformatf("rnd_pc c%0d", cyc), OutPC, mq[0].pc);
            chk($sformatf("rnd_ins c%0d", cyc), OutInstruction, mq[0].ins);
            chk($sformatf("rnd_pc4 c%0d", cyc), OutPCPlus4, mq[0].pc + 32'd4);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic fill_linear();
        for (int i = 0; i < 512; i++) mem[i] = i * 3;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, OutValid}, 32'd0);
        chk({tag, "_addr"}, ImemAddress, 32'd0);
        chk({tag, "_ins"}, OutInstruction, 32'd0);
        chk({tag, "_pc"}, OutPC, 32'd0);
        chk({tag, "_pc4"}, OutPCPlus4, 32'd0);
        chk({tag, "_halted"}, {31'd0, Halted}, 32'd0);
        chk({tag, "_fault"}, {31'd0, Fault}, 32'd0);
    endtask

    task automatic do_reset();
        Reset_n        = 1'b0;
        Start          = 1'b0;
        OutReady       = 1'b0;
        RedirectValid  = 1'b0;
        RedirectTarget = 32'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          start;
        bit          rdy;
        bit          rv;
        logic [31:0] rt;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] addr;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mk(bit s, bit r, bit v, logic [31:0] t, bit ev, logic [31:0] ep,
                                logic [31:0] ei, logic [31:0] ea);
        vec_t x;
        x.start = s; x.rdy = r; x.rv = v; x.rt = t;
        x.valid = ev; x.pc = ep; x.ins = ei; x.addr = ea;
        return x;
    endfunction

    int          hcyc;
    logic [31:0] last_pc;
    logic [31:0] got[$];
    logic [31:0] sel;

    initial begin
        Reset_n        = 1'b1;
        Start          = 1'b0;
        OutReady       = 1'b0;
        RedirectValid  = 1'b0;
        RedirectTarget = 32'd0;
        fill_linear();

        // Sequential fetch, backpressure on cycles 3-6, redirect to 0x40 with a full buffer.
        vt[0]  = mk(1, 1, 0, 32'h0,  0, 32'h0,  32'h0,  32'h0);
        vt[1]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h0,  32'h0);
        vt[2]  = mk(0, 1, 0, 32'h0,  1, 32'h0,  32'h0,  32'h4);
        vt[3]  = mk(0, 0, 0, 32'h0,  1, 32'h4,  32'h3,  32'h8);
        vt[4]  = mk(0, 0, 0, 32'h0,  1, 32'h4,  32'h3,  32'hC);
        vt[5]  = mk(0, 0, 0, 32'h0,  1, 32'h4,  32'h3,  32'hC);
        vt[6]  = mk(0, 0, 0, 32'h0,  1, 32'h4,  32'h3,  32'hC);
        vt[7]  = mk(0, 1, 0, 32'h0,  1, 32'h4,  32'h3,  32'hC);
        vt[8]  = mk(0, 1, 0, 32'h0,  1, 32'h8,  32'h6,  32'h10);
        vt[9]  = mk(0, 1, 0, 32'h0,  1, 32'hC,  32'h9,  32'h14);
        vt[10] = mk(0, 1, 1, 32'h40, 1, 32'h10, 32'hC,  32'h18);
        vt[11] = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h0,  32'h40);
        vt[12] = mk(0, 1, 0, 32'h0,  1, 32'h40, 32'h30, 32'h44);
        vt[13] = mk(0, 1, 0, 32'h0,  1, 32'h44, 32'h33, 32'h48);

        // Reset values while reset is asserted.
        #1 Reset_n = 1'b0;
        #3;
        check_reset_outputs("reset");
        do_reset();

        for (int i = 0; i < 14; i++) begin
            Start          = vt[i].start;
            OutReady       = vt[i].rdy;
            RedirectValid  = vt[i].rv;
            RedirectTarget = vt[i].rt;
            @(negedge Clk);
            chk($sformatf("vec%0d_valid", i), {31'd0, OutValid}, {31'd0, vt[i].valid});
            chk($sformatf("vec%0d_addr", i), ImemAddress, vt[i].addr);
            if (vt[i].valid) begin
                chk($sformatf("vec%0d_pc", i), OutPC, vt[i].pc);
                chk($sformatf("vec%0d_ins", i), OutInstruction, vt[i].ins);
                chk($sformatf("vec%0d_pc4", i), OutPCPlus4, vt[i].pc + 32'd4);
            end
            next_cycle();
        end

        // Halt word at 0x10: drain, then Halted two cycles after it is seen.
        do_reset();
        mem[4]   = HALT;
        Start    = 1'b1;
        OutReady = 1'b1;
        hcyc     = -1;
        last_pc  = 32'hDEAD_BEEF;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (OutValid && OutReady) last_pc = OutPC;
            if (Halted && hcyc < 0) hcyc = k;
            next_cycle();
            Start = 1'b0;
        end
        chk("halt_last_pc", last_pc, 32'hC);
        chk("halt_cycle", hcyc, 32'd7);
        chk("halt_addr", ImemAddress, 32'h10);
        RedirectValid  = 1'b1;
        RedirectTarget = 32'h80;
        repeat (3) next_cycle();
        RedirectValid = 1'b0;
        @(negedge Clk);
        chk("halt_redir_halted", {31'd0, Halted}, 32'd1);
        chk("halt_redir_addr", ImemAddress, 32'h10);
        chk("halt_redir_valid", {31'd0, OutValid}, 32'd0);
        chk("halt_redir_fault", {31'd0, Fault}, 32'd0);
        next_cycle();
        mem[4] = 32'hC;

        // Misaligned redirect faults.
        do_reset();
        Start    = 1'b1;
        OutReady = 1'b1;
        next_cycle();
        Start = 1'b0;
        repeat (3) next_cycle();
        RedirectValid  = 1'b1;
        RedirectTarget = 32'h42;
        next_cycle();
        RedirectValid = 1'b0;
        @(negedge Clk);
        chk("mis_fault", {31'd0, Fault}, 32'd1);
        chk("mis_halted", {31'd0, Halted}, 32'd1);
        chk("mis_valid", {31'd0, OutValid}, 32'd0);
        chk("mis_addr", ImemAddress, 32'h42);
        next_cycle();

        // Fetch past a 0x0C limit on the second instance.
        do_reset();
        got.delete();
        Start    = 1'b1;
        OutReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (l_valid && OutReady) got.push_back(l_out_pc);
            next_cycle();
            Start = 1'b0;
        end
        chk("lim_count", got.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk($sformatf("lim_pc%0d", k), got[k], k * 4);
        end
        @(negedge Clk);
        chk("lim_fault", {31'd0, l_fault}, 32'd1);
        chk("lim_halted", {31'd0, l_halted}, 32'd1);
        chk("lim_addr", l_addr, 32'h10);
        chk("lim_valid", {31'd0, l_valid}, 32'd0);
        next_cycle();

        // Asynchronous reset between clock edges mid-stream, then restart.
        do_reset();
        Start    = 1'b1;
        OutReady = 1'b0;
        next_cycle();
        Start = 1'b0;
        repeat (4) next_cycle();
        #2 Reset_n = 1'b0;
        #1;
        check_reset_outputs("areset");
        #1 Reset_n = 1'b1;
        next_cycle();
        OutReady = 1'b1;
        Start    = 1'b1;
        next_cycle();
        Start = 1'b0;
        @(negedge Clk);
        chk("arst_c1_addr", ImemAddress, 32'h0);
        next_cycle();
        @(negedge Clk);
        chk("arst_c2_valid", {31'd0, OutValid}, 32'd1);
        chk("arst_c2_pc", OutPC, 32'h0);
        next_cycle();

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            model_reset();
            for (int i = 0; i < 512; i++) begin
                mem[i] = ($urandom_range(0, 40) == 0) ? HALT : $urandom;
            end
            for (int c = 0; c < 120; c++) begin
                Start         = (c == 0) || ($urandom_range(0, 15) == 0);
                OutReady      = ($urandom_range(0, 9) < 7);
                RedirectValid = ($urandom_range(0, 19) == 0);
                sel           = $urandom_range(0, 7);
                if (sel == 0)      RedirectTarget = ($urandom_range(0, 511) << 2) | $urandom_range(1, 3);
                else if (sel == 1) RedirectTarget = 32'h7F0 + ($urandom_range(0, 3) << 2);
                else if (sel == 2) RedirectTarget = 32'hFFFF_FFFC;
                else               RedirectTarget = $urandom_range(0, 511) << 2;
                @(negedge Clk);
                compare_model(ep * 1000 + c);
                model_step(Start, OutReady, RedirectValid, RedirectTarget);
                next_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
